reduction_grant_scheduler: RTL and testbench
============================================

// Module: reduction_grant_scheduler
// PURPOSE
//  Arbitrates the single reduction-table read-modify-write pipeline among the 7 local-port ejection FIFOs
//  (local, yneg, ypos, xpos, xneg, zpos, zneg). Issues at most one reduction grant per cycle, round-robin.
//  Blocks read-after-write hazards on the same table index while an earlier packet is still in the RR/WB stages.
//  Sits between the FIFO heads (consume strobes) and the RR stage select of the local-port mux.
// PARAMETERS
//  NumPorts    7   requesting FIFOs; port ids 0..6, id 7 = none
//  IndexWidth  16  reduction table index width
//  PipeDepth   2   in-flight stages tracked for hazards (RR, WB)
// PORTS
//  clk          in   1                    clock
//  rst          in   1                    reset, asynchronous, active-low
//  req          in   NumPorts             FIFO i non-empty and head has reduction bit set
//  req_index    in   NumPorts*IndexWidth  head table index, port i at [i*IndexWidth +: IndexWidth]
//  out_stall    in   1                    downstream reduction pipeline frozen this cycle
//  grant        out  NumPorts             one-hot consume strobe to FIFO i (combinational, same cycle)
//  grant_valid  out  1                    registered: a packet entered RR stage this cycle
//  grant_port   out  3                    registered port id of that packet; 7 when grant_valid=0
//  grant_index  out  IndexWidth           registered table index of that packet; 0 when invalid
//  hazard_stall out  1                    combinational: req!=0, out_stall=0, but no port eligible due to hazard
// BEHAVIOUR
//  - Reset (rst=0, async): rr_ptr=0, tracker all invalid, grant_valid=0, grant_port=7, grant_index=0.
//    grant and hazard_stall are 0 while in reset. A reset mid-stream drops every in-flight entry; nothing is replayed.
//  - Eligibility: elig[i] = req[i] & ~out_stall & ~hit[i].
//    hit[i] = req_index[i] equals the index of any valid tracker entry.
//  - Pick: the first eligible port searching rr_ptr, rr_ptr+1, ... mod 7 (6 wraps to 0).
//    grant = onehot(pick), or 0 if none eligible. An ineligible port never blocks a later eligible port.
//  - After a grant to port p: rr_ptr <= (p==6) ? 0 : p+1. With no grant, rr_ptr holds.
//  - Latency: the grant strobe is in the same cycle as the request.
//    grant_valid/grant_port/grant_index follow 1 cycle later and form tracker stage 0 (RR).
//  - Tracker: PipeDepth-entry shift register of {valid,index}. Stage 0 loads the current grant, or invalid if none.
//    Stage k loads stage k-1. The last stage is discarded after WB.
//  - out_stall=1: no grant. The tracker and all registered outputs hold their values and rr_ptr holds.
//    Hazard compare remains active against held entries.
//  - Simultaneous: several ports with the same index -> only one granted; the rest hit next cycle.
//    They are granted only after that entry leaves WB (earliest PipeDepth+1 cycles later, absent stalls).
//  - Fairness: any continuously eligible port is granted within 7 grant cycles.
//  - Index compare is full IndexWidth equality; no partial or alias matching.
// STRUCTURE
//  - Shared package constants: PORT_LOCAL=0, PORT_YNEG=1, PORT_YPOS=2, PORT_XPOS=3, PORT_XNEG=4,
//    PORT_ZPOS=5, PORT_ZNEG=6, PORT_NONE=3'd7, NUM_PORTS=7.
//  - Sub-module rr_priority_picker: combinational rotate by rr_ptr, find-first, rotate back.
//    Outputs onehot + id + any. Reusable for the non-local muxes.
//  - Top level holds rr_ptr, the hazard tracker, comparators and output registers.
// TESTING
//  1. Reset: hold rst=0 with req=7'h7F -> grant=0, grant_port=7, grant_valid=0.
//     Release -> first grant is port 0.
//  2. Round-robin: req=7'h7F, all indices distinct and never reused.
//     Grants cycle 0,1,...,6,0. grant_port follows 1 cycle later.
//  3. Hazard: port 2 index 0x0010 granted at cycle t. Port 2 re-requests 0x0010 at t+1 and t+2 -> grant 0.
//     No other requester, so hazard_stall=1. Grant occurs at t+3.
//  4. Bypass: port 1 hits index 0x0005 in flight, port 4 requests 0x0006 -> port 4 granted same cycle.
//     hazard_stall=0.
//  5. Stall: out_stall=1 for 3 cycles mid-stream -> no grant; grant_* and tracker frozen.
//     After release, the sequence resumes at the held rr_ptr.
//  6. Wrap + async reset: grant port 6 -> rr_ptr=0, next grant port 0.
//     Assert rst mid-cycle -> outputs clear immediately without waiting for a clock edge.

Source files
------------

// File: rtl/reduction_grant_scheduler_pkg.sv
// Shared port ids, sizes and tracker entry type for the reduction grant scheduler.
// Pure declarations: no latency, no flow control.
package reduction_grant_scheduler_pkg;

  localparam int NUM_PORTS   = 7;
  localparam int INDEX_WIDTH = 16;
  localparam int PIPE_DEPTH  = 2;
  localparam int PORT_ID_W   = 3;

  typedef logic [PORT_ID_W-1:0]   port_id_t;
  typedef logic [INDEX_WIDTH-1:0] tbl_index_t;

  localparam port_id_t PORT_LOCAL = 3'd0;
  localparam port_id_t PORT_YNEG  = 3'd1;
  localparam port_id_t PORT_YPOS  = 3'd2;
  localparam port_id_t PORT_XPOS  = 3'd3;
  localparam port_id_t PORT_XNEG  = 3'd4;
  localparam port_id_t PORT_ZPOS  = 3'd5;
  localparam port_id_t PORT_ZNEG  = 3'd6;
  localparam port_id_t PORT_NONE  = 3'd7;

  typedef struct packed {
    logic       vld;
    tbl_index_t idx;
  } trk_entry_t;

  function automatic port_id_t next_port(input port_id_t p);
    return (p == PORT_ZNEG) ? PORT_LOCAL : port_id_t'(p + 3'd1);
  endfunction

endpackage

// File: rtl/reduction_grant_scheduler_rr_priority_picker.sv
// Round-robin find-first: rotate requests by ptr, pick lowest, rotate the id back.
// Purely combinational; ptr_i must be below N.
module rr_priority_picker #(
  parameter int                N       = 7,
  parameter int                ID_W    = 3,
  parameter logic [ID_W-1:0]   NONE_ID = '1
) (
  input  logic [N-1:0]    req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [N-1:0]    onehot_o,
  output logic [ID_W-1:0] id_o,
  output logic            any_o
);

  logic [N-1:0] rot;

  always_comb begin
    int k;
    int off;
    rot      = '0;
    onehot_o = '0;
    id_o     = NONE_ID;
    for (int j = 0; j < N; j++) begin
      k = int'(ptr_i) + j;
      if (k >= N) k = k - N;
      rot[j] = req_i[k];
    end
    off = 0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) off = j;
    end
    any_o = |rot;
    k = int'(ptr_i) + off;
    if (k >= N) k = k - N;
    if (any_o) begin
      onehot_o[k] = 1'b1;
      id_o        = ID_W'(k);
    end
  end

endmodule

// File: rtl/reduction_grant_scheduler.sv
// Grants one reduction FIFO per cycle (same-cycle strobe), skipping heads whose index is still in RR/WB.
// grant_* registered one cycle later; out_stall freezes grants, rr_ptr, tracker and outputs.
module reduction_grant_scheduler
  import reduction_grant_scheduler_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             req,
  input  logic [NUM_PORTS*INDEX_WIDTH-1:0] req_index,
  input  logic                             out_stall,
  output logic [NUM_PORTS-1:0]             grant,
  output logic                             grant_valid,
  output logic [PORT_ID_W-1:0]             grant_port,
  output logic [INDEX_WIDTH-1:0]           grant_index,
  output logic                             hazard_stall
);

  port_id_t             rr_ptr_q, rr_ptr_d;
  port_id_t             gport_q, gport_d;
  trk_entry_t           trk_q [PIPE_DEPTH];
  trk_entry_t           trk_d [PIPE_DEPTH];
  logic [NUM_PORTS-1:0] hit;
  logic [NUM_PORTS-1:0] elig;
  logic [NUM_PORTS-1:0] pick_1h;
  port_id_t             pick_id;
  logic                 pick_any;
  logic                 issue_en;
  tbl_index_t           pick_index;

  // Gating with rst keeps the combinational strobes quiet while reset is held.
  assign issue_en = rst & ~out_stall;

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        if (trk_q[k].vld && (trk_q[k].idx == req_index[i*INDEX_WIDTH +: INDEX_WIDTH])) begin
          hit[i] = 1'b1;
        end
      end
    end
  end

  assign elig = req & ~hit & {NUM_PORTS{issue_en}};

  rr_priority_picker #(
    .N       (NUM_PORTS),
    .ID_W    (PORT_ID_W),
    .NONE_ID (PORT_NONE)
  ) u_picker (
    .req_i    (elig),
    .ptr_i    (rr_ptr_q),
    .onehot_o (pick_1h),
    .id_o     (pick_id),
    .any_o    (pick_any)
  );

  assign grant        = pick_1h;
  assign hazard_stall = issue_en & (|req) & ~pick_any;

  always_comb begin
    pick_index = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (pick_1h[i]) pick_index = req_index[i*INDEX_WIDTH +: INDEX_WIDTH];
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    gport_d  = gport_q;
    trk_d    = trk_q;
    if (!out_stall) begin
      trk_d[0].vld = pick_any;
      trk_d[0].idx = pick_index;
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        trk_d[k] = trk_q[k-1];
      end
      gport_d = pick_id;
      if (pick_any) rr_ptr_d = next_port(pick_id);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q <= PORT_LOCAL;
      gport_q  <= PORT_NONE;
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        trk_q[k] <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      gport_q  <= gport_d;
      trk_q    <= trk_d;
    end
  end

  assign grant_valid = trk_q[0].vld;
  assign grant_index = trk_q[0].idx;
  assign grant_port  = gport_q;

endmodule

// File: tb/tb_reduction_grant_scheduler.sv
// Randomised and directed bench for reduction_grant_scheduler against a tick-based reference model.
module tb_reduction_grant_scheduler;
  import reduction_grant_scheduler_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [6:0]   req;
  logic [111:0] req_index;
  logic         out_stall;
  logic [6:0]   grant;
  logic         grant_valid;
  logic [2:0]   grant_port;
  logic [15:0]  grant_index;
  logic         hazard_stall;

  reduction_grant_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_index    (req_index),
    .out_stall    (out_stall),
    .grant        (grant),
    .grant_valid  (grant_valid),
    .grant_port   (grant_port),
    .grant_index  (grant_index),
    .hazard_stall (hazard_stall)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: a packet granted on non-stalled tick g blocks its index on ticks g+1..g+PIPE_DEPTH.
  int   m_ptr;
  int   m_tick;
  int   m_last [int];
  logic m_gv;
  int   m_gp;
  int   m_gi;
  int   m_pick;
  logic m_haz;

  logic [6:0] last_grant;
  logic       last_haz;
  int         fresh = 32'h1000;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [111:0] ix, input int p);
    return int'(ix[p*16 +: 16]);
  endfunction

  function automatic logic [111:0] seq_idx(input int base);
    logic [111:0] v;
    for (int p = 0; p < 7; p++) v[p*16 +: 16] = 16'(base + p);
    return v;
  endfunction

  function automatic logic [111:0] next_fresh();
    logic [111:0] v;
    v = seq_idx(fresh);
    fresh = fresh + 7;
    return v;
  endfunction

  task automatic model_reset();
    m_ptr  = 0;
    m_tick = 0;
    m_last.delete();
    m_gv   = 1'b0;
    m_gp   = 7;
    m_gi   = 0;
  endtask

  function automatic bit model_hit(input int ix);
    return m_last.exists(ix) && ((m_tick - m_last[ix]) <= PIPE_DEPTH);
  endfunction

  task automatic model_eval();
    int p;
    m_pick = -1;
    if (!out_stall) begin
      for (int j = 0; j < 7; j++) begin
        p = (m_ptr + j) % 7;
        if (req[p] && !model_hit(idx_of(req_index, p))) begin
          m_pick = p;
          break;
        end
      end
    end
    m_haz = (req != 7'd0) && !out_stall && (m_pick < 0);
  endtask

  task automatic model_commit();
    if (!out_stall) begin
      m_gv = (m_pick >= 0);
      m_gp = (m_pick >= 0) ? m_pick : 7;
      m_gi = (m_pick >= 0) ? idx_of(req_index, m_pick) : 0;
      if (m_pick >= 0) begin
        m_last[m_gi] = m_tick;
        m_ptr = (m_pick + 1) % 7;
      end
      m_tick++;
    end
  endtask

  // Entered and left at posedge+1.
  task automatic cycle(input logic [6:0] r, input logic [111:0] ix, input logic st);
    logic [6:0] eg;
    check_eq("grant_valid", 32'(grant_valid), 32'(m_gv));
    check_eq("grant_port", 32'(grant_port), m_gp);
    check_eq("grant_index", 32'(grant_index), m_gi);
    req       = r;
    req_index = ix;
    out_stall = st;
    #1;
    model_eval();
    eg = '0;
    if (m_pick >= 0) eg[m_pick] = 1'b1;
    check_eq("grant", 32'(grant), 32'(eg));
    check_eq("hazard_stall", 32'(hazard_stall), 32'(m_haz));
    last_grant = grant;
    last_haz   = hazard_stall;
    @(posedge clk);
    model_commit();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [111:0] ix;
    int           saved_ptr;
    int           held_gp;
    int           held_gi;

    rst       = 1'b0;
    req       = 7'h7F;
    req_index = next_fresh();
    out_stall = 1'b0;
    model_reset();
    #12;
    check_eq("rst_grant", 32'(grant), 0);
    check_eq("rst_grant_port", 32'(grant_port), 7);
    check_eq("rst_grant_valid", 32'(grant_valid), 0);
    check_eq("rst_grant_index", 32'(grant_index), 0);
    check_eq("rst_hazard", 32'(hazard_stall), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    cycle(7'h7F, next_fresh(), 1'b0);
    check_eq("first_grant_port0", 32'(last_grant), 32'h01);

    for (int i = 0; i < 9; i++) begin
      cycle(7'h7F, next_fresh(), 1'b0);
      check_eq("rr_seq", 32'(last_grant), 32'(1) << ((i + 1) % 7));
    end

    ix = next_fresh();
    ix[2*16 +: 16] = 16'h0010;
    cycle(7'h04, ix, 1'b0);
    check_eq("hz_t0_grant", 32'(last_grant), 32'h04);
    cycle(7'h04, ix, 1'b0);
    check_eq("hz_t1_grant", 32'(last_grant), 0);
    check_eq("hz_t1_stall", 32'(last_haz), 1);
    cycle(7'h04, ix, 1'b0);
    check_eq("hz_t2_grant", 32'(last_grant), 0);
    check_eq("hz_t2_stall", 32'(last_haz), 1);
    cycle(7'h04, ix, 1'b0);
    check_eq("hz_t3_grant", 32'(last_grant), 32'h04);

    ix = next_fresh();
    ix[1*16 +: 16] = 16'h0005;
    ix[4*16 +: 16] = 16'h0006;
    cycle(7'h02, ix, 1'b0);
    check_eq("byp_first", 32'(last_grant), 32'h02);
    cycle(7'h12, ix, 1'b0);
    check_eq("byp_grant", 32'(last_grant), 32'h10);
    check_eq("byp_hazard", 32'(last_haz), 0);

    cycle(7'h7F, next_fresh(), 1'b0);
    cycle(7'h7F, next_fresh(), 1'b0);
    saved_ptr = m_ptr;
    held_gp   = m_gp;
    held_gi   = m_gi;
    for (int i = 0; i < 3; i++) begin
      cycle(7'h7F, next_fresh(), 1'b1);
      check_eq("stall_grant", 32'(last_grant), 0);
      check_eq("stall_hold_port", 32'(grant_port), held_gp);
      check_eq("stall_hold_index", 32'(grant_index), held_gi);
    end
    cycle(7'h7F, next_fresh(), 1'b0);
    check_eq("stall_resume", 32'(last_grant), 32'(1) << saved_ptr);

    cycle(7'h40, next_fresh(), 1'b0);
    check_eq("wrap_p6", 32'(last_grant), 32'h40);
    cycle(7'h7F, next_fresh(), 1'b0);
    check_eq("wrap_p0", 32'(last_grant), 32'h01);

    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < 7; p++) ix[p*16 +: 16] = 16'($urandom_range(0, 7));
      cycle(7'($urandom), ix, ($urandom_range(0, 7) == 0));
    end

    cycle(7'h7F, next_fresh(), 1'b0);
    rst = 1'b0;
    #1;
    check_eq("arst_grant_valid", 32'(grant_valid), 0);
    check_eq("arst_grant_port", 32'(grant_port), 7);
    check_eq("arst_grant_index", 32'(grant_index), 0);
    check_eq("arst_grant", 32'(grant), 0);
    check_eq("arst_hazard", 32'(hazard_stall), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycle(7'h7F, next_fresh(), 1'b0);
    check_eq("arst_first_port0", 32'(last_grant), 32'h01);
    cycle(7'h00, next_fresh(), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
